// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch request channel, data request
// channel, shared memory port, grant status and abort flag.
// The arbiter connects through the slave modport; requesters and the
// memory model connect through the master modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ack;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [BE_W-1:0]       d_be;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_W-1:0]       mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic [1:0]            grant;
    logic                  err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output grant, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  grant, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// fetch stage (read-only) and the MEM stage (read/write). One access at a
// time, data wins simultaneous requests, and on completion the port hands
// over directly to a waiting other requester so fetch starves for at most
// one data access. The memory port is driven from registered copies of the
// winning request; the ack and read data are combinational with mem_ready.
// Optional build macro ARB_TIMEOUT_EN: adds a wait counter that aborts an
// access (ack with err=1, rdata=0) after TIMEOUT cycles without mem_ready.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    // State encoding doubles as the grant vector.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_IF   = 2'b01;
    localparam logic [1:0] ST_D    = 2'b10;

    logic [1:0]            state_r;
    logic [1:0]            next_state_s;
    logic                  load_if_s;
    logic                  load_d_s;
    logic                  complete_s;
    logic                  timeout_s;
    logic                  err_s;
    logic                  if_ack_s;
    logic                  d_ack_s;
    logic [DATA_WIDTH-1:0] if_rdata_s;
    logic [DATA_WIDTH-1:0] d_rdata_s;

    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic [BE_W-1:0]       mem_be_r;

`ifdef ARB_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_r;

    // Count stalled memory cycles of the current access; restart on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) || load_if_s || load_d_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (mem_req_r && !bus.mem_ready && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Abort fires the cycle after TIMEOUT stalled cycles have been counted.
    assign timeout_s = (state_r != ST_IDLE) && (wait_cnt_r == TIMEOUT_C);
    assign err_s     = (if_ack_s || d_ack_s) && timeout_s;
`else
    assign timeout_s = 1'b0;
    assign err_s     = 1'b0;
`endif

    // An access ends on mem_ready or on an abort.
    assign complete_s = (state_r != ST_IDLE) && (bus.mem_ready || timeout_s);

    // Next-state selection: data priority from idle, direct hand-over on completion.
    always_comb begin
        next_state_s = state_r;
        load_if_s    = 1'b0;
        load_d_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.d_req) begin
                    next_state_s = ST_D;
                    load_d_s     = 1'b1;
                end else if (bus.if_req) begin
                    next_state_s = ST_IF;
                    load_if_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_IF: begin
                if (complete_s && bus.d_req) begin
                    next_state_s = ST_D;
                    load_d_s     = 1'b1;
                end else if (complete_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IF;
                end
            end
            ST_D: begin
                if (complete_s && bus.if_req) begin
                    next_state_s = ST_IF;
                    load_if_s    = 1'b1;
                end else if (complete_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_D;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Owner ack and read data; suppressed while reset is asserted.
    always_comb begin
        if_ack_s   = 1'b0;
        d_ack_s    = 1'b0;
        if_rdata_s = {DATA_WIDTH{1'b0}};
        d_rdata_s  = {DATA_WIDTH{1'b0}};
        if (!rst && complete_s && (state_r == ST_IF)) begin
            if_ack_s   = 1'b1;
            if_rdata_s = timeout_s ? {DATA_WIDTH{1'b0}} : bus.mem_rdata;
        end else if (!rst && complete_s && (state_r == ST_D)) begin
            d_ack_s   = 1'b1;
            d_rdata_s = timeout_s ? {DATA_WIDTH{1'b0}} : bus.mem_rdata;
        end else begin
            if_ack_s = 1'b0;
            d_ack_s  = 1'b0;
        end
    end

    // State register and registered memory-port copy of the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            mem_req_r <= (next_state_s != ST_IDLE);
            if (load_d_s) begin
                mem_we_r    <= bus.d_we;
                mem_addr_r  <= bus.d_addr;
                mem_wdata_r <= bus.d_wdata;
                mem_be_r    <= bus.d_be;
            end else if (load_if_s) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= bus.if_addr;
                mem_wdata_r <= {DATA_WIDTH{1'b0}};
                mem_be_r    <= {BE_W{1'b1}};
            end else if (next_state_s == ST_IDLE) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_be_r    <= mem_be_r;
            end else begin
                mem_we_r    <= mem_we_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_be_r    <= mem_be_r;
            end
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.grant     = state_r;
    assign bus.if_ack    = if_ack_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.d_ack     = d_ack_s;
    assign bus.d_rdata   = d_rdata_s;
    assign bus.err       = err_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Each scenario task drives the
// requesters and the memory handshake cycle by cycle and checks port values
// inline; every expected ack is pushed to a scoreboard queue when the
// completing memory cycle is driven and popped by an ack monitor.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t mon_e;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ack monitor: pops the scoreboard on every ack and checks owner, data and err.
    always @(negedge clk) begin
        if (bus.if_ack === 1'b1 && bus.d_ack === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL double_ack: both acks high at %0t", $time);
        end else if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: if_ack=%b d_ack=%b with no expected ack at %0t",
                         bus.if_ack, bus.d_ack, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.d_ack !== mon_e.is_d
                    || (mon_e.is_d ? bus.d_rdata : bus.if_rdata) !== mon_e.rdata
                    || (mon_e.is_d ? bus.if_rdata : bus.d_rdata) !== 32'h0
                    || bus.err !== mon_e.err) begin
                    errors++;
                    $display("FAIL ack_scoreboard: got d_ack=%b if_rdata=%h d_rdata=%h err=%b, want d_ack=%b rdata=%h err=%b at %0t",
                             bus.d_ack, bus.if_rdata, bus.d_rdata, bus.err,
                             mon_e.is_d, mon_e.rdata, mon_e.err, $time);
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        settle();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: mem_req=%b mem_we=%b grant=%b, want 0 0 00", bus.mem_req, bus.mem_we, bus.grant);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h be=%h, want zeros", bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        checks++;
        if (bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: if_ack=%b d_ack=%b err=%b, want 0 0 0", bus.if_ack, bus.d_ack, bus.err);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hBFC0_0000;
        settle();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_latency c0: mem_req=%b, want 0", bus.mem_req);
        end
        tick();
        settle();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.grant !== 2'b01
            || bus.mem_addr !== 32'hBFC0_0000 || bus.mem_be !== 4'hF || bus.mem_wdata !== 32'h0 || bus.if_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c1: req=%b we=%b grant=%b addr=%h be=%h wdata=%h ack=%b, want 1 0 01 bfc00000 f 0 0",
                     bus.mem_req, bus.mem_we, bus.grant, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.if_ack);
        end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        exp_q.push_back('{1'b0, 32'h0050_0093, 1'b0});
        settle();
        checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h0050_0093 || bus.mem_req !== 1'b1 || bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL fetch_c2: ack=%b rdata=%h req=%b grant=%b, want 1 00500093 1 01",
                     bus.if_ack, bus.if_rdata, bus.mem_req, bus.grant);
        end
        tick();
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        settle();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00 || bus.if_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c3: req=%b grant=%b ack=%b, want 0 00 0", bus.mem_req, bus.grant, bus.if_ack);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0200;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        exp_q.push_back('{1'b1, 32'h1111_1111, 1'b0});
        settle();
        checks++;
        if (bus.grant !== 2'b10 || bus.d_ack !== 1'b1 || bus.mem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL simul_c1: grant=%b d_ack=%b addr=%h, want 10 1 00000200", bus.grant, bus.d_ack, bus.mem_addr);
        end
        tick();
        bus.d_req     = 1'b0;
        bus.mem_rdata = 32'h2222_2222;
        exp_q.push_back('{1'b0, 32'h2222_2222, 1'b0});
        settle();
        checks++;
        if (bus.grant !== 2'b01 || bus.if_ack !== 1'b1 || bus.mem_addr !== 32'h0000_0300 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL simul_c2: grant=%b if_ack=%b addr=%h we=%b, want 01 1 00000300 0",
                     bus.grant, bus.if_ack, bus.mem_addr, bus.mem_we);
        end
        tick();
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        settle();
        checks++;
        if (bus.grant !== 2'b00 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL simul_c3: grant=%b req=%b, want 00 0", bus.grant, bus.mem_req);
        end
    endtask

    task automatic test_store();
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be    = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_0100
                || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_be !== 4'b0011 || bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0) begin
                errors++;
                $display("FAIL store_wait%0d: req=%b we=%b addr=%h wdata=%h be=%b acks=%b%b, want 1 1 00000100 deadbeef 0011 00",
                         i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.d_ack, bus.if_ack);
            end
        end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hA5A5_A5A5;
        exp_q.push_back('{1'b1, 32'hA5A5_A5A5, 1'b0});
        settle();
        checks++;
        if (bus.d_ack !== 1'b1 || bus.if_ack !== 1'b0 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL store_done: d_ack=%b if_ack=%b we=%b, want 1 0 1", bus.d_ack, bus.if_ack, bus.mem_we);
        end
        tick();
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_be      = 4'b0000;
        bus.mem_ready = 1'b0;
        settle();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.d_ack !== 1'b0) begin
            errors++;
            $display("FAIL store_idle: req=%b we=%b d_ack=%b, want 0 0 0", bus.mem_req, bus.mem_we, bus.d_ack);
        end
    endtask

    task automatic test_alternation();
        logic [31:0] rd;
        logic [1:0]  want_grant;
        tick();
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_0400;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0500;
        bus.mem_ready = 1'b1;
        settle();
        checks++;
        if (bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0) begin
            errors++;
            $display("FAIL alt_idle_ready: acks=%b%b, want 00 (mem_ready in idle)", bus.d_ack, bus.if_ack);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) bus.d_req = 1'b0;
            rd         = 32'h0000_1000 + 32'(k);
            want_grant = (k % 2 == 1) ? 2'b10 : 2'b01;
            bus.mem_rdata = rd;
            exp_q.push_back('{(k % 2 == 1), rd, 1'b0});
            settle();
            checks++;
            if (bus.grant !== want_grant) begin
                errors++;
                $display("FAIL alt_grant%0d: grant=%b, want %b", k, bus.grant, want_grant);
            end
        end
        tick();
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        settle();
        checks++;
        if (bus.grant !== 2'b00 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL alt_end: grant=%b req=%b, want 00 0", bus.grant, bus.mem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        tick();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0600;
        tick();
        settle();
        checks++;
        if (bus.grant !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_grant: grant=%b, want 10", bus.grant);
        end
        tick();
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        settle();
        checks++;
        if (bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ack: d_ack=%b if_ack=%b, want 0 0", bus.d_ack, bus.if_ack);
        end
        tick();
        rst       = 1'b0;
        bus.d_req = 1'b0;
        settle();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00 || bus.d_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: req=%b grant=%b d_ack=%b, want 0 00 0", bus.mem_req, bus.grant, bus.d_ack);
        end
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        tick();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0700;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            tick();
            settle();
            checks++;
            if (bus.if_ack !== 1'b0 || bus.mem_req !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait%0d: if_ack=%b req=%b, want 0 1", c, bus.if_ack, bus.mem_req);
            end
        end
        tick();
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        settle();
        checks++;
        if (bus.if_ack !== 1'b1 || bus.err !== 1'b1 || bus.if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort: if_ack=%b err=%b rdata=%h, want 1 1 00000000", bus.if_ack, bus.err, bus.if_rdata);
        end
        tick();
        bus.if_req = 1'b0;
        settle();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL timeout_end: req=%b grant=%b, want 0 00", bus.mem_req, bus.grant);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            tick();
            settle();
            checks++;
            if (bus.if_ack !== 1'b0 || bus.mem_req !== 1'b1 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout%0d: if_ack=%b req=%b err=%b, want 0 1 0", c, bus.if_ack, bus.mem_req, bus.err);
            end
        end
        tick();
        rst        = 1'b1;
        bus.if_req = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL no_timeout_end: req=%b grant=%b, want 0 00", bus.mem_req, bus.grant);
        end
`endif
    endtask

    // Scenario sequence and summary.
    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.d_be      = 4'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;

        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_alternation();
        test_reset_mid_access();
        test_timeout();

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: %0d expected acks never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
